// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-serial memory engine between instruction fetch and the load/store buffer
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LSB_ID_WIDTH = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    io_buffer_full,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_done,
  output logic [31:0]             if_data,
  input  logic                    lsb_req,
  input  logic                    lsb_we,
  input  logic [ADDR_WIDTH-1:0]   lsb_addr,
  input  logic [31:0]             lsb_wdata,
  input  logic [2:0]              lsb_funct3,
  input  logic [LSB_ID_WIDTH-1:0] lsb_id,
  output logic                    lsb_gnt,
  output logic                    lsb_done,
  output logic [LSB_ID_WIDTH-1:0] lsb_done_id,
  output logic [31:0]             lsb_rdata,
  output logic                    mem_busy,
  output logic                    eng_req,
  output logic                    eng_we,
  output logic [ADDR_WIDTH-1:0]   eng_addr,
  output logic [31:0]             eng_wdata,
  output logic [1:0]              eng_len,
  output logic                    eng_abort,
  input  logic                    eng_done,
  input  logic [31:0]             eng_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, IO_WAIT, BUSY_IF, BUSY_LSB} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [2:0] f3_q, f3_d;
  logic [LSB_ID_WIDTH-1:0] id_q, id_d;
  logic if_gnt_q, if_gnt_d, if_done_q, if_done_d, lsb_gnt_q, lsb_gnt_d, lsb_done_q, lsb_done_d;
  logic busy_q, busy_d, eng_req_q, eng_req_d, eng_we_q, eng_we_d, eng_abort_q, eng_abort_d;
  logic [31:0] if_data_q, if_data_d, lsb_rdata_q, lsb_rdata_d, eng_wdata_q, eng_wdata_d;
  logic [ADDR_WIDTH-1:0] eng_addr_q, eng_addr_d;
  logic [1:0] eng_len_q, eng_len_d;
  logic io_block, lsb_win;
  logic [31:0] load_ext;
  assign if_gnt      = if_gnt_q;
  assign if_done     = if_done_q;
  assign if_data     = if_data_q;
  assign lsb_gnt     = lsb_gnt_q;
  assign lsb_done    = lsb_done_q;
  assign lsb_done_id = id_q;
  assign lsb_rdata   = lsb_rdata_q;
  assign mem_busy    = busy_q;
  assign eng_req     = eng_req_q;
  assign eng_we      = eng_we_q;
  assign eng_addr    = eng_addr_q;
  assign eng_wdata   = eng_wdata_q;
  assign eng_len     = eng_len_q;
  assign eng_abort   = eng_abort_q;
  // a store into UART space must wait while the output buffer is full; LSB wins unless fetch has starved
  always_comb begin
    io_block = lsb_we && (lsb_addr[17:16] == 2'b11) && io_buffer_full;
    lsb_win  = lsb_req && (!if_req || starve_q < LIM);
  end
  // sign or zero extension of the raw engine bytes by the latched access type
  always_comb begin
    load_ext = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & eng_rdata[7]}}, eng_rdata[7:0]} :
               (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & eng_rdata[15]}}, eng_rdata[15:0]} : eng_rdata;
  end
  // arbitration, engine sequencing and flush handling; pulses default low, data holds
  always_comb begin
    state_d     = state_q;
    starve_d    = flush ? '0 : starve_q;
    f3_d        = f3_q;
    id_d        = id_q;
    if_gnt_d    = 1'b0;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    lsb_gnt_d   = 1'b0;
    lsb_done_d  = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    busy_d      = busy_q;
    eng_req_d   = 1'b0;
    eng_we_d    = eng_we_q;
    eng_addr_d  = eng_addr_q;
    eng_wdata_d = eng_wdata_q;
    eng_len_d   = eng_len_q;
    eng_abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && lsb_win) begin
          lsb_gnt_d   = 1'b1;
          busy_d      = 1'b1;
          starve_d    = if_req ? starve_q + 1'b1 : '0;
          f3_d        = lsb_funct3;
          id_d        = lsb_id;
          eng_we_d    = lsb_we;
          eng_addr_d  = lsb_addr;
          eng_wdata_d = lsb_wdata;
          eng_len_d   = lsb_funct3[1] ? 2'd3 : {1'b0, lsb_funct3[0]};
          eng_req_d   = !io_block;
          state_d     = io_block ? IO_WAIT : BUSY_LSB;
        end else if (!flush && if_req) begin
          if_gnt_d    = 1'b1;
          starve_d    = '0;
          eng_we_d    = 1'b0;
          eng_addr_d  = if_addr;
          eng_wdata_d = '0;
          eng_len_d   = 2'd3;
          eng_req_d   = 1'b1;
          state_d     = BUSY_IF;
        end
      end
      IO_WAIT: begin
        if (!io_buffer_full) begin
          eng_req_d = 1'b1;
          state_d   = BUSY_LSB;
        end
      end
      BUSY_IF: begin
        if (flush) begin
          eng_abort_d = 1'b1;
          state_d     = IDLE;
        end else if (eng_done) begin
          if_done_d = 1'b1;
          if_data_d = eng_rdata;
          state_d   = IDLE;
        end
      end
      BUSY_LSB: begin
        if (flush && !eng_we_q) begin
          eng_abort_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else if (eng_done) begin
          lsb_done_d  = 1'b1;
          lsb_rdata_d = eng_we_q ? '0 : load_ext;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // all state and outputs registered; rdy_in low freezes everything
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      f3_q        <= '0;
      id_q        <= '0;
      if_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      lsb_gnt_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= '0;
      busy_q      <= 1'b0;
      eng_req_q   <= 1'b0;
      eng_we_q    <= 1'b0;
      eng_addr_q  <= '0;
      eng_wdata_q <= '0;
      eng_len_q   <= '0;
      eng_abort_q <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      f3_q        <= f3_d;
      id_q        <= id_d;
      if_gnt_q    <= if_gnt_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      lsb_gnt_q   <= lsb_gnt_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
      busy_q      <= busy_d;
      eng_req_q   <= eng_req_d;
      eng_we_q    <= eng_we_d;
      eng_addr_q  <= eng_addr_d;
      eng_wdata_q <= eng_wdata_d;
      eng_len_q   <= eng_len_d;
      eng_abort_q <= eng_abort_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_in, rdy_in, flush, io_buffer_full, if_req, lsb_req, lsb_we, eng_done;
  logic [31:0] if_addr, lsb_addr, lsb_wdata, eng_rdata, if_data, lsb_rdata, eng_addr, eng_wdata;
  logic [2:0] lsb_funct3, lsb_id, lsb_done_id;
  logic if_gnt, if_done, lsb_gnt, lsb_done, mem_busy, eng_req, eng_we, eng_abort;
  logic [1:0] eng_len;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic is_if; logic [2:0] id; logic [31:0] data;} exp_t;
  exp_t sb[$];

  mem_arbiter dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_funct3(lsb_funct3), .lsb_id(lsb_id), .lsb_gnt(lsb_gnt), .lsb_done(lsb_done),
    .lsb_done_id(lsb_done_id), .lsb_rdata(lsb_rdata), .mem_busy(mem_busy), .eng_req(eng_req),
    .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_len(eng_len),
    .eng_abort(eng_abort), .eng_done(eng_done), .eng_rdata(eng_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic sb_pop();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_underflow observed=0 expected=nonzero");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("done_seen", 32'(if_done | lsb_done), 32'd1);
      chk("done_kind", 32'(if_done), 32'(e.is_if));
      if (e.is_if) chk("if_data", if_data, e.data);
      else begin
        chk("lsb_done_id", 32'(lsb_done_id), 32'(e.id));
        chk("lsb_rdata", lsb_rdata, e.data);
      end
    end
  endtask

  task automatic eng_finish(input logic [31:0] raw);
    eng_rdata = raw;
    eng_done  = 1'b1;
    tick();
    eng_done  = 1'b0;
  endtask

  task automatic lsb_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [2:0] id);
    lsb_req = 1'b1; lsb_we = we; lsb_addr = addr; lsb_wdata = wdata; lsb_funct3 = f3; lsb_id = id;
  endtask

  task automatic lsb_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [2:0] id, input logic [31:0] raw,
                        input logic [31:0] exp_d, input logic [1:0] len);
    sb.push_back('{1'b0, id, exp_d});
    lsb_issue(we, addr, wdata, f3, id);
    tick();
    lsb_req = 1'b0;
    chk("lsb_gnt", 32'(lsb_gnt), 32'd1);
    chk("eng_req", 32'(eng_req), 32'd1);
    chk("eng_addr", eng_addr, addr);
    chk("eng_len", 32'(eng_len), 32'(len));
    chk("eng_we", 32'(eng_we), 32'(we));
    chk("mem_busy_set", 32'(mem_busy), 32'd1);
    if (we) chk("eng_wdata", eng_wdata, wdata);
    tick();
    chk("gnt_pulse", 32'(lsb_gnt), 32'd0);
    eng_finish(raw);
    sb_pop();
    chk("mem_busy_clr", 32'(mem_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1; rdy_in = 1; flush = 0; io_buffer_full = 0; if_req = 0; lsb_req = 0; lsb_we = 0;
    eng_done = 0; if_addr = 0; lsb_addr = 0; lsb_wdata = 0; eng_rdata = 0; lsb_funct3 = 0; lsb_id = 0;
    tick(); tick();
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_lsb_gnt", 32'(lsb_gnt), 32'd0);
    chk("rst_eng_req", 32'(eng_req), 32'd0);
    chk("rst_mem_busy", 32'(mem_busy), 32'd0);
    chk("rst_eng_abort", 32'(eng_abort), 32'd0);
    chk("rst_done", 32'(if_done | lsb_done), 32'd0);
    chk("rst_eng_addr", eng_addr, 32'd0);
    rst_in = 0;
    tick();
    // fetch only, cycle-exact
    sb.push_back('{1'b1, 3'd0, 32'h00A00093});
    if_req = 1; if_addr = 32'h1000;
    tick();
    if_req = 0;
    chk("f_if_gnt", 32'(if_gnt), 32'd1);
    chk("f_eng_req", 32'(eng_req), 32'd1);
    chk("f_eng_addr", eng_addr, 32'h1000);
    chk("f_eng_len", 32'(eng_len), 32'd3);
    chk("f_eng_we", 32'(eng_we), 32'd0);
    chk("f_no_busy", 32'(mem_busy), 32'd0);
    for (int i = 2; i <= 6; i++) begin
      tick();
      chk("f_wait_no_done", 32'(if_done | if_gnt | eng_req), 32'd0);
    end
    eng_finish(32'h00A00093);
    sb_pop();
    // loads of every width and a store
    lsb_op(0, 32'h20, 0, 3'b000, 3'd5, 32'h000000F0, 32'hFFFFFFF0, 2'd0);
    lsb_op(0, 32'h20, 0, 3'b100, 3'd6, 32'h000000F0, 32'h000000F0, 2'd0);
    lsb_op(0, 32'h21, 0, 3'b000, 3'd3, 32'hFFFFFF7F, 32'h0000007F, 2'd0);
    lsb_op(0, 32'h22, 0, 3'b101, 3'd1, 32'h00008001, 32'h00008001, 2'd1);
    lsb_op(0, 32'h22, 0, 3'b001, 3'd7, 32'hABCD8001, 32'hFFFF8001, 2'd1);
    lsb_op(0, 32'h24, 0, 3'b010, 3'd4, 32'h12345678, 32'h12345678, 2'd3);
    lsb_op(1, 32'h40, 32'hCAFEF00D, 3'b010, 3'd2, 32'h55555555, 32'h0, 2'd3);
    // starvation: four LSB grants, then fetch, then LSB again
    lsb_issue(0, 32'h80, 0, 3'b010, 3'd3);
    if_req = 1; if_addr = 32'h3000;
    for (int g = 0; g < 6; g++) begin
      int n = 0;
      tick();
      while (!(if_gnt || lsb_gnt) && n < 10) begin
        tick();
        n++;
      end
      chk("st_grant_seen", 32'(if_gnt | lsb_gnt), 32'd1);
      chk("st_grant_is_if", 32'(if_gnt), (g == 4) ? 32'd1 : 32'd0);
      sb.push_back('{(g == 4), 3'd3, 32'(32'h100 + g)});
      if (g == 5) begin
        lsb_req = 0;
        if_req  = 0;
      end
      tick();
      eng_finish(32'(32'h100 + g));
      sb_pop();
    end
    // IO store throttled while the UART buffer is full
    io_buffer_full = 1;
    sb.push_back('{1'b0, 3'd2, 32'h0});
    lsb_issue(1, 32'h30000, 32'hDEADBEEF, 3'b000, 3'd2);
    tick();
    lsb_req = 0;
    chk("io_gnt", 32'(lsb_gnt), 32'd1);
    chk("io_no_req", 32'(eng_req), 32'd0);
    chk("io_busy", 32'(mem_busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("io_wait_no_req", 32'(eng_req), 32'd0);
      chk("io_wait_busy", 32'(mem_busy), 32'd1);
    end
    io_buffer_full = 0;
    tick();
    chk("io_req", 32'(eng_req), 32'd1);
    chk("io_addr", eng_addr, 32'h30000);
    chk("io_wdata", eng_wdata, 32'hDEADBEEF);
    chk("io_we", 32'(eng_we), 32'd1);
    chk("io_len", 32'(eng_len), 32'd0);
    chk("io_busy2", 32'(mem_busy), 32'd1);
    tick();
    eng_finish(32'h12345678);
    sb_pop();
    io_buffer_full = 1;
    lsb_op(0, 32'h30004, 0, 3'b010, 3'd1, 32'h89ABCDEF, 32'h89ABCDEF, 2'd3);
    lsb_op(1, 32'h20000, 32'h1, 3'b000, 3'd6, 32'h0, 32'h0, 2'd0);
    io_buffer_full = 0;
    // flush aborts a fetch
    if_req = 1; if_addr = 32'h2000;
    tick();
    if_req = 0;
    chk("fl_if_gnt", 32'(if_gnt), 32'd1);
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("fl_if_abort", 32'(eng_abort), 32'd1);
    chk("fl_if_no_done", 32'(if_done), 32'd0);
    tick();
    chk("fl_abort_pulse", 32'(eng_abort), 32'd0);
    eng_finish(32'h00000BAD);
    chk("fl_idle_done_ignored", 32'(if_done | lsb_done), 32'd0);
    // flush with coincident eng_done aborts a load and discards the data
    lsb_issue(0, 32'h50, 0, 3'b010, 3'd4);
    tick();
    lsb_req = 0;
    chk("fl_ld_gnt", 32'(lsb_gnt), 32'd1);
    tick();
    flush = 1; eng_done = 1; eng_rdata = 32'h77777777;
    tick();
    flush = 0; eng_done = 0;
    chk("fl_ld_abort", 32'(eng_abort), 32'd1);
    chk("fl_ld_no_done", 32'(lsb_done), 32'd0);
    chk("fl_ld_busy", 32'(mem_busy), 32'd0);
    // flush never kills a store
    sb.push_back('{1'b0, 3'd5, 32'h0});
    lsb_issue(1, 32'h60, 32'h0BADF00D, 3'b010, 3'd5);
    tick();
    lsb_req = 0;
    chk("fl_st_gnt", 32'(lsb_gnt), 32'd1);
    flush = 1;
    tick();
    flush = 0;
    chk("fl_st_no_abort", 32'(eng_abort), 32'd0);
    chk("fl_st_busy", 32'(mem_busy), 32'd1);
    eng_finish(32'h0);
    sb_pop();
    // flush in IDLE suppresses the grant for that cycle only
    sb.push_back('{1'b0, 3'd7, 32'h0000005A});
    lsb_issue(0, 32'h70, 0, 3'b010, 3'd7);
    flush = 1;
    tick();
    flush = 0;
    chk("fl_idle_no_gnt", 32'(lsb_gnt), 32'd0);
    tick();
    lsb_req = 0;
    chk("fl_idle_gnt_after", 32'(lsb_gnt), 32'd1);
    tick();
    eng_finish(32'h0000005A);
    sb_pop();
    // rdy_in low freezes a pending completion
    sb.push_back('{1'b0, 3'd3, 32'hFFFFFF80});
    lsb_issue(0, 32'h90, 0, 3'b000, 3'd3);
    tick();
    lsb_req = 0;
    chk("rdy_gnt", 32'(lsb_gnt), 32'd1);
    tick();
    rdy_in = 0; eng_done = 1; eng_rdata = 32'h00000080;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_frozen_no_done", 32'(lsb_done), 32'd0);
      chk("rdy_frozen_busy", 32'(mem_busy), 32'd1);
    end
    rdy_in = 1;
    tick();
    eng_done = 0;
    sb_pop();
    // reset mid-fetch returns to IDLE without an abort
    if_req = 1; if_addr = 32'h4000;
    tick();
    if_req = 0;
    chk("rs_gnt", 32'(if_gnt), 32'd1);
    tick();
    rst_in = 1;
    tick();
    rst_in = 0;
    chk("rs_no_abort", 32'(eng_abort), 32'd0);
    chk("rs_addr_clr", eng_addr, 32'd0);
    eng_finish(32'h1);
    chk("rs_done_ignored", 32'(if_done), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
